// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, selects the result by OutSel and drives the register-file write port. Optional retire counter under RETIRE_CNT_EN.
// Latency: a non-load writes 1 cycle after capture; a load writes 1 cycle after its mem_done cycle.
// Backpressure: in_ready is low while waiting on data memory and after HALT retires.
module wb_stage #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    input  logic [2:0]    OutSel,
    input  logic          IsLoad,
    input  logic          IsHalt,
    input  logic          RegWr,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] AluOut,
    input  logic [DW-1:0] BtrOut,
    input  logic [DW-1:0] Rs,
    input  logic [DW-1:0] Imm,
    input  logic [DW-1:0] PcPlus2,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          RegWrEn,
    output logic [AW-1:0] RegWrAddr,
    output logic [DW-1:0] RegWrData,
    output logic          halted
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, MEMWAIT, WB} state_t;

    state_t        state, state_nxt;
    logic          capture;
    logic          cap_wr;
    logic [DW-1:0] cap_data;

    // Held instruction: pre-muxed result plus what the load completion still needs.
    logic          wr_ok_q;
    logic          halt_q;
    logic          sel_rd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] rdata_q;

    logic          unused_ok;
    assign unused_ok = ^{Rs[DW-1:8], Imm[DW-1:8]};

    assign in_ready = (state != MEMWAIT) && !halted;
    assign capture  = in_valid && in_ready && !flush;
    assign cap_wr   = RegWr && !IsHalt && (OutSel != 3'd7);
    assign RegWrEn  = (state == WB) && wr_ok_q;

    always_comb begin
        cap_data = '0;
        case (OutSel)
            3'd0: cap_data = BtrOut;
            3'd1: cap_data = DW'(1);
            3'd2: cap_data = AluOut;
            3'd3: cap_data = PcPlus2;
            3'd4: cap_data = Imm;
            3'd5: cap_data = DW'({Rs[7:0], Imm[7:0]});
            3'd6: cap_data = rdata_q;
            default: cap_data = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WB: begin
                if (capture)
                    state_nxt = IsLoad ? MEMWAIT : WB;
                else
                    state_nxt = IDLE;
            end
            MEMWAIT: begin
                if (mem_done)
                    state_nxt = WB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ok_q   <= 1'b0;
            halt_q    <= 1'b0;
            sel_rd_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            RegWrAddr <= '0;
            RegWrData <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                wr_ok_q  <= cap_wr;
                halt_q   <= IsHalt;
                sel_rd_q <= (OutSel == 3'd6);
                addr_q   <= WrAddr;
                data_q   <= cap_data;
                // Output registers only move for a real write so they hold otherwise.
                if (!IsLoad && cap_wr) begin
                    RegWrAddr <= WrAddr;
                    RegWrData <= cap_data;
                end
                if (!IsLoad && IsHalt)
                    halted <= 1'b1;
            end else if (state == MEMWAIT && mem_done) begin
                rdata_q <= mem_rdata;
                if (wr_ok_q) begin
                    RegWrAddr <= addr_q;
                    RegWrData <= sel_rd_q ? mem_rdata : data_q;
                end
                if (halt_q)
                    halted <= 1'b1;
            end
        end
    end

`ifdef RETIRE_CNT_EN
    // No WB cycle can follow a HALT retirement, so counting WB cycles freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (state == WB)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 16-bit five-stage pipeline; consumes the 3-bit writeback select code produced by the output-control logic at end of execute, together with the operands it selects between.
- Holds one instruction and waits on multi-cycle data memory for loads.
- Drives the register-file write port; back-pressures the memory stage.

Parameters:
DW, 16, datapath width
AW, 3, register-file address width (8 GPRs)

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can capture this cycle
flush  input  1  squash the instruction presented this cycle
OutSel  input  3  writeback select code
IsLoad  input  1  instruction reads data memory
IsHalt  input  1  instruction is HALT
RegWr  input  1  instruction writes a register
WrAddr  input  AW  destination register
AluOut  input  DW  ALU result
BtrOut  input  DW  bit-reversed Rs
Rs  input  DW  source register value (for SLBI)
Imm  input  DW  sign-extended immediate
PcPlus2  input  DW  link value
mem_done  input  1  data-memory read complete
mem_rdata  input  DW  data-memory read data
RegWrEn  output  1  register-file write strobe
RegWrAddr  output  AW  register-file write address
RegWrData  output  DW  register-file write data
halted  output  1  sticky: HALT has retired

Behaviour:
- Reset (async, rst_n low): state IDLE; RegWrEn=0, RegWrAddr=0, RegWrData=0, halted=0; holding register cleared. Takes effect immediately, including mid-MEMWAIT; pending load discarded.
- Capture: on rising edge when in_valid & in_ready & ~flush, all inputs are latched. flush=1 makes that cycle's capture a no-op (bubble).
- in_ready = (state != MEMWAIT) & ~halted.
- States:
  - IDLE: nothing held. Capture of a non-load -> WB. Capture of a load -> MEMWAIT.
  - MEMWAIT: in_ready=0. On a mem_done cycle, mem_rdata is latched -> WB next cycle. mem_done is ignored in every other state.
  - WB: RegWrEn = latched RegWr for exactly this one cycle, with RegWrAddr/RegWrData valid. A new capture in the same cycle goes to WB (non-load) or MEMWAIT (load); with no capture -> IDLE.
- Latency: non-load writes the register file 1 cycle after capture. Load writes 1 cycle after the mem_done cycle.
- RegWrData by latched OutSel; all results are truncated or extended to DW:
  - 0: BtrOut
  - 1: 16'h0001
  - 2: AluOut (also used for set-false, which the ALU supplies as 0)
  - 3: PcPlus2
  - 4: Imm
  - 5: {Rs[7:0], Imm[7:0]}
  - 6: mem_rdata (latched)
  - 7: 16'h0000, RegWrEn forced 0
- A load with OutSel != 6 still waits for mem_done but writes the selected value.
- RegWrAddr, RegWrData hold their last values when RegWrEn=0.
- HALT: when a latched IsHalt reaches WB, halted sets at that edge and stays set until reset; in_ready drops. HALT never writes, regardless of RegWr.
- Simultaneous events:
  - flush in a cycle where WB is retiring does not affect the retiring instruction.
  - mem_done in the same cycle as entry to MEMWAIT is not seen; the done must come from the cycle after capture onward.

Optional Feature:
- Macro RETIRE_CNT_EN.
- When defined: adds output retire_cnt [31:0]. It increments by 1 on every WB-state cycle (including HALT and RegWr=0 instructions), wraps from 32'hFFFFFFFF to 0, resets to 0, and freezes once halted=1.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU op (OutSel=2, AluOut=16'h1234, WrAddr=5) captured at cycle 1 -> cycle 2: RegWrEn=1, RegWrAddr=5, RegWrData=16'h1234; cycle 3: RegWrEn=0.
- Load (IsLoad=1, OutSel=6), mem_done with mem_rdata=16'hBEEF after 3 cycles -> in_ready=0 throughout the wait; RegWrData=16'hBEEF exactly one cycle after mem_done; a back-to-back ALU op is accepted only in the WB cycle.
- SLBI (OutSel=5, Rs=16'h00AB, Imm=16'hFFCD) -> RegWrData=16'hABCD. LBI (OutSel=4, Imm=16'hFF80) -> 16'hFF80. Set-true (OutSel=1) -> 16'h0001.
- flush with in_valid=1 for an ALU op -> no RegWrEn pulse. rst_n low during MEMWAIT -> state IDLE; a later mem_done causes no write.
- HALT with RegWr=1 -> RegWrEn stays 0, halted=1 next edge, in_ready=0 afterwards. With RETIRE_CNT_EN after 4 retirements including the HALT -> retire_cnt=4 and constant afterwards.
